// File: rtl/spi_slave_module.sv
// SPI responder with an Avalon-MM register port: DATA (TX hold / RX FIFO), STATUS, CTRL.
// Optional level interrupt output `irq` is built when SPI_SLAVE_IRQ_EN is defined.
module spi_slave_module #(
    parameter int unsigned RX_DEPTH    = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic        chipselect,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe
`ifdef SPI_SLAVE_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int unsigned PTR_W = $clog2(RX_DEPTH);
    localparam int unsigned PW1   = PTR_W + 1;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q, rd_acc_prev_q;
    logic [9:0]             ctrl_q, ctrl_d;
    logic [31:0]            tx_hold_q, tx_hold_d;
    logic                   txhf_q, txhf_d, txu_q, txu_d, rxfo_q, rxfo_d;
    logic [31:0]            tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic [4:0]             wsz_q, wsz_d;
    logic                   cpol_q, cpol_d, cpha_q, cpha_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PTR_W:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0]            rx_mem_q [RX_DEPTH];
    logic                   miso_q, miso_d, oe_q, oe_d;
    logic                   push, push_ok;

    logic sclk_s, cs_s, mosi_s, lead, trail, sample_edge, shift_edge, cs_fall;
    logic rx_empty, rx_full, rd_acc, pop, bus_wr;

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    // Leading edge is a rise of sclk normalised by the latched CPOL
    assign lead        = (sclk_s ^ cpol_q) & ~(sclk_prev_q ^ cpol_q);
    assign trail       = ~(sclk_s ^ cpol_q) & (sclk_prev_q ^ cpol_q);
    assign sample_edge = cpha_q ? trail : lead;
    assign shift_edge  = cpha_q ? lead : trail;
    assign cs_fall     = ~cs_s & cs_prev_q;
    assign rx_empty    = (wr_ptr_q == rd_ptr_q);
    assign rx_full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                         (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign rd_acc      = read && chipselect && (address == 2'd0);
    assign pop         = rd_acc && !rd_acc_prev_q && !rx_empty;
    assign bus_wr      = write && chipselect;
    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;

    // Input synchronisers and edge-detect history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync_q   <= '0;
            cs_sync_q     <= '1;
            mosi_sync_q   <= '0;
            sclk_prev_q   <= 1'b0;
            cs_prev_q     <= 1'b1;
            rd_acc_prev_q <= 1'b0;
        end else begin
            sclk_sync_q   <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            cs_sync_q     <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q   <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_q   <= sclk_s;
            cs_prev_q     <= cs_s;
            rd_acc_prev_q <= rd_acc;
        end
    end

    // Next-state: register writes, frame FSM, FIFO pointers and sticky flags
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        tx_hold_d  = tx_hold_q;
        txhf_d     = txhf_q;
        txu_d      = txu_q;
        rxfo_d     = rxfo_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        wsz_d      = wsz_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW1'(1) : rd_ptr_q;
        push       = 1'b0;
        push_ok    = 1'b0;

        // W1C is applied before the FSM so a same-cycle set event wins
        if (bus_wr) begin
            case (address)
                2'd0: tx_hold_d = writedata;
                2'd1: begin
                    if (writedata[2]) rxfo_d = 1'b0;
                    if (writedata[4]) txu_d  = 1'b0;
                end
                2'd2: ctrl_d = writedata[9:0];
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (ctrl_q[5] && cs_fall) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                wsz_d      = ctrl_q[4:0];
                cpha_d     = ctrl_q[6];
                cpol_d     = ctrl_q[7];
                cnt_d      = '0;
                rx_shift_d = '0;
                if (txhf_q) begin
                    tx_shift_d = tx_hold_q;
                    txhf_d     = 1'b0;
                end else begin
                    tx_shift_d = '0;
                    txu_d      = 1'b1;
                end
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cs_s || !ctrl_q[5]) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    // First shift edge of a word only presents the MSB
                    if (shift_edge && (cnt_q != '0)) tx_shift_d = tx_shift_q << 1;
                    if (sample_edge) begin
                        rx_shift_d = {rx_shift_q[30:0], mosi_s};
                        cnt_d      = cnt_q + CNT_W'(1);
                        if (cnt_d == CNT_W'(wsz_q) + CNT_W'(1)) begin
                            push    = 1'b1;
                            state_d = ST_LOAD;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A DATA write in the LOAD cycle refills the holding register after the copy
        if (bus_wr && (address == 2'd0)) txhf_d = 1'b1;

        if (push) begin
            if (!rx_full || pop) begin
                push_ok  = 1'b1;
                wr_ptr_d = wr_ptr_q + PW1'(1);
            end else begin
                rxfo_d = 1'b1;
            end
        end

        miso_d = tx_shift_d[wsz_d];
        oe_d   = ctrl_q[5] && !cs_s;
    end

    // State and control registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            tx_hold_q  <= '0;
            txhf_q     <= 1'b0;
            txu_q      <= 1'b0;
            rxfo_q     <= 1'b0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            wsz_q      <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            tx_hold_q  <= tx_hold_d;
            txhf_q     <= txhf_d;
            txu_q      <= txu_d;
            rxfo_q     <= rxfo_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            wsz_q      <= wsz_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
        end
    end

    // RX FIFO storage; occupancy is tracked by the pointers alone
    always_ff @(posedge clk) begin
        if (push_ok) rx_mem_q[wr_ptr_q[PTR_W-1:0]] <= rx_shift_d;
    end

    // Combinational read mux
    always_comb begin
        readdata = '0;
        if (read && chipselect) begin
            case (address)
                2'd0: readdata = rx_empty ? 32'h0 : rx_mem_q[rd_ptr_q[PTR_W-1:0]];
                2'd1: readdata = {26'h0, (state_q != ST_IDLE), txu_q, txhf_q,
                                  rxfo_q, rx_full, rx_empty};
                2'd2: readdata = {22'h0, ctrl_q};
                default: readdata = '0;
            endcase
        end
    end

`ifdef SPI_SLAVE_IRQ_EN
    logic irq_q, irq_d;

    // Level interrupt from RX-not-empty and error flags
    always_comb begin
        irq_d = (ctrl_q[8] && !rx_empty) || (ctrl_q[9] && (rxfo_q || txu_q));
    end

    // Registered interrupt output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_spi_slave_module.sv
// Directed bench for spi_slave_module: acts as SPI master and Avalon host.
module tb_spi_slave_module;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        read, write, chipselect;
    logic [1:0]  address;
    logic [31:0] writedata, readdata;
    logic        spi_sclk, spi_cs_n, spi_mosi, spi_miso, spi_miso_oe;
`ifdef SPI_SLAVE_IRQ_EN
    logic        irq;
`endif

    int   n_checks = 0;
    int   n_bad    = 0;
    logic oe_seen;

    always #10 clk = ~clk;

    spi_slave_module #(.RX_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .read(read), .write(write),
        .chipselect(chipselect), .address(address), .writedata(writedata),
        .readdata(readdata), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
`ifdef SPI_SLAVE_IRQ_EN
        , .irq(irq)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        #1 d = readdata;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
    endtask

    // Master frame: nbits MSB-first, MISO captured on the master's sample edge
    task automatic spi_xfer(input logic cpol, input logic cpha, input int nbits,
                            input logic [63:0] mo, output logic [63:0] mi);
        mi = '0;
        spi_sclk = cpol;
        repeat (8) @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!cpha) begin
                spi_mosi = mo[i];
                repeat (HALF) @(negedge clk);
                spi_sclk = ~spi_sclk;
                mi = {mi[62:0], spi_miso};
                repeat (HALF) @(negedge clk);
                spi_sclk = ~spi_sclk;
            end else begin
                spi_sclk = ~spi_sclk;
                spi_mosi = mo[i];
                repeat (HALF) @(negedge clk);
                spi_sclk = ~spi_sclk;
                mi = {mi[62:0], spi_miso};
                repeat (HALF) @(negedge clk);
            end
            if (i == nbits / 2) oe_seen = spi_miso_oe;
        end
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic [63:0] mi;
        logic        cpol, cpha;

        reset = 1'b0; read = 1'b0; write = 1'b0; chipselect = 1'b0;
        address = 2'd0; writedata = '0;
        spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0; oe_seen = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso", 64'(spi_miso), 64'h0);
        check("rst_oe", 64'(spi_miso_oe), 64'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(2'd1, rd); check("rst_status", 64'(rd), 64'h01);
        bus_read(2'd2, rd); check("rst_ctrl", 64'(rd), 64'h0);
        #1 check("idle_readdata", 64'(readdata), 64'h0);

        // Mode 0, 8-bit word
        bus_write(2'd2, 32'h27);
        bus_write(2'd0, 32'hA5);
        bus_read(2'd1, rd); check("m0_status_pre", 64'(rd), 64'h09);
        spi_xfer(1'b0, 1'b0, 8, 64'h3C, mi);
        check("m0_miso", mi, 64'hA5);
        check("m0_oe_mid", 64'(oe_seen), 64'h1);
        bus_read(2'd0, rd); check("m0_data", 64'(rd), 64'h3C);
        bus_read(2'd1, rd); check("m0_status_post", 64'(rd & 32'h2F), 64'h01);

        // Modes 1..3, 32-bit word
        for (int m = 1; m <= 3; m++) begin
            cpha = 1'(m & 1);
            cpol = 1'(m >> 1);
            bus_write(2'd2, {24'h0, cpol, cpha, 6'h3F});
            bus_write(2'd0, 32'hDEADBEEF);
            spi_xfer(cpol, cpha, 32, 64'h12345678, mi);
            check($sformatf("mode%0d_miso", m), mi, 64'hDEADBEEF);
            bus_read(2'd0, rd);
            check($sformatf("mode%0d_data", m), 64'(rd), 64'h12345678);
        end

        // Five back-to-back words overflow a 4-deep FIFO; holding register stays empty
        bus_write(2'd2, 32'h27);
        spi_xfer(1'b0, 1'b0, 40, 64'h0102030405, mi);
        check("ovf_miso", mi, 64'h0);
        bus_read(2'd1, rd); check("ovf_status", 64'(rd), 64'h16);
        for (int k = 1; k <= 4; k++) begin
            bus_read(2'd0, rd);
            check($sformatf("ovf_data%0d", k), 64'(rd), 64'(k));
        end
        bus_read(2'd1, rd); check("ovf_status_drained", 64'(rd), 64'h15);
        bus_write(2'd1, 32'h4);
        bus_read(2'd1, rd); check("rxfo_w1c", 64'(rd), 64'h11);
        bus_write(2'd1, 32'h10);
        bus_read(2'd1, rd); check("txu_w1c", 64'(rd), 64'h01);

        // cs_n raised after 3 of 8 bits
        spi_xfer(1'b0, 1'b0, 3, 64'h5, mi);
        check("abort_miso", mi, 64'h0);
        check("abort_oe_mid", 64'(oe_seen), 64'h1);
        check("abort_oe_after", 64'(spi_miso_oe), 64'h0);
        bus_read(2'd1, rd); check("abort_status", 64'(rd), 64'h11);

        // Read held for several cycles pops once
        spi_xfer(1'b0, 1'b0, 16, 64'h1122, mi);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = 2'd0;
        #1 check("held_first", 64'(readdata), 64'h11);
        repeat (4) @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        #1 check("held_idle_readdata", 64'(readdata), 64'h0);
        bus_read(2'd0, rd); check("held_second", 64'(rd), 64'h22);
        bus_read(2'd1, rd); check("held_status", 64'(rd & 32'h0F), 64'h01);
        bus_read(2'd0, rd); check("empty_read", 64'(rd), 64'h0);

        // Reset pulsed in the middle of a frame
        bus_write(2'd0, 32'h55);
        spi_sclk = 1'b0;
        spi_cs_n = 1'b0;
        repeat (16) @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            spi_sclk = 1'b1; repeat (HALF) @(negedge clk);
            spi_sclk = 1'b0; repeat (HALF) @(negedge clk);
        end
        check("pre_rst_oe", 64'(spi_miso_oe), 64'h1);
        bus_read(2'd1, rd); check("pre_rst_busy", 64'(rd & 32'h20), 64'h20);
        reset = 1'b0;
        #1;
        check("mid_rst_miso", 64'(spi_miso), 64'h0);
        check("mid_rst_oe", 64'(spi_miso_oe), 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus_read(2'd2, rd); check("post_rst_ctrl", 64'(rd), 64'h0);
        bus_read(2'd1, rd); check("post_rst_status", 64'(rd), 64'h01);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);

`ifdef SPI_SLAVE_IRQ_EN
        // RX-not-empty interrupt follows the FIFO level
        bus_write(2'd2, 32'h127);
        spi_xfer(1'b0, 1'b0, 8, 64'h5A, mi);
        check("irq_set", 64'(irq), 64'h1);
        bus_read(2'd0, rd); check("irq_data", 64'(rd), 64'h5A);
        @(negedge clk);
        check("irq_clear", 64'(irq), 64'h0);
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_module.md
Name: spi_slave_module

Overview:
SPI responder (slave) with an Avalon-MM register interface: the far end of the team's SPI master. It synchronises the external spi_sclk/spi_cs_n/spi_mosi into the clk domain. It shifts words of programmable length (1-32 bits) in any of SPI modes 0-3. Received words go into an RX FIFO; transmit words come from a single-entry TX holding register. The block sits on the HPS lightweight bus next to spi_module.

Parameters:
RX_DEPTH, 4, RX FIFO entries; power of 2, minimum 2
SYNC_STAGES, 2, flip-flop stages on each SPI input; minimum 2

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-low reset
read  in  1  Avalon read strobe
write  in  1  Avalon write strobe
chipselect  in  1  Avalon chip select
address  in  2  register select: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved
writedata  in  32  write data
readdata  out  32  read data, combinational; 0 when not (read && chipselect)
spi_sclk  in  1  SPI clock from the master
spi_cs_n  in  1  chip select from the master, active-low
spi_mosi  in  1  master-out data
spi_miso  out  1  slave-out data
spi_miso_oe  out  1  tri-state enable for spi_miso

Behaviour:
- Reset (reset=0, async): CTRL=0; TX holding register empty and cleared; RX FIFO empty; all sticky flags 0; FSM in IDLE; spi_miso=0; spi_miso_oe=0.
- CTRL fields:
  - [4:0] WSZ; word length = WSZ+1 bits.
  - [5] ENABLE.
  - [6] CPHA.
  - [7] CPOL.
  - [8] IRQ_RX_EN, [9] IRQ_ERR_EN (used only with the optional feature).
  - Other bits read back 0.
- STATUS fields:
  - [0] RXFE, [1] RXFF.
  - [2] RXFO: sticky, write-1-to-clear.
  - [3] TXHF: holding register full.
  - [4] TXU: sticky underrun, write-1-to-clear.
  - [5] BUSY: frame active.
  - Writes to other bits are ignored.
  - A set event and a W1C in the same cycle: set wins.
- DATA write: loads the TX holding register and sets TXHF. If TXHF is already 1, the new value overwrites the old one (last write wins).
- DATA read: returns the RX FIFO head, zero-extended; returns 0 when the FIFO is empty.
  - The pop happens on the clk edge that ends the first cycle of the read access (rising-edge detect of read&&chipselect&&address==0).
  - A read held for several cycles pops exactly once.
  - A read of an empty FIFO does not pop.
- Input synchronisation: SYNC_STAGES flip-flops per input, then edge detect on the synchronised signals. Input-to-action latency is SYNC_STAGES+1 clk cycles. spi_sclk must be no faster than clk/8.
- Edge definitions:
  - Leading edge is rising when CPOL=0, falling when CPOL=1.
  - CPHA=0: sample MOSI on the leading edge, shift MISO on the trailing edge.
  - CPHA=1: shift MISO on the leading edge, sample MOSI on the trailing edge.
  - Data is MSB first.
- FSM states:
  - IDLE -> LOAD when ENABLE=1 and synchronised cs_n falls.
  - LOAD (1 cycle): latch WSZ/CPOL/CPHA for the frame. If TXHF=1, copy the holding register into the TX shifter and clear TXHF; otherwise load 0 and set TXU. Clear the bit counter. Go to SHIFT.
  - SHIFT: each sample edge shifts in MOSI and increments the counter.
    - When the counter reaches WSZ+1: push the RX word (bits [WSZ:0], upper bits 0) and return to LOAD for continuous back-to-back words.
    - For CPHA=0, the first bit of the next word is presented after LOAD completes.
- spi_miso = TX shifter bit [WSZ_latched]. spi_miso_oe = ENABLE && synchronised cs_n==0.
- Boundary conditions:
  - Push when the FIFO is full: the word is dropped and RXFO is set. Push and pop in the same cycle while full: both succeed, no overflow.
  - cs_n rises mid-word: the partial word is discarded (no push), counter cleared, return to IDLE, spi_miso_oe drops within SYNC_STAGES+1 cycles.
  - ENABLE cleared mid-frame: abort as for cs_n rise; the FIFO and holding register are retained.
  - CTRL writes during a frame take effect at the next LOAD.
  - Pointer wrap uses an extra MSB for full/empty discrimination.

Optional Feature:
Macro SPI_SLAVE_IRQ_EN.
- Defined: adds output port irq (1 bit, registered, reset 0). irq = (IRQ_RX_EN && !RXFE) || (IRQ_ERR_EN && (RXFO||TXU)). Level-sensitive; deasserts one cycle after the cause clears.
- Undefined: no irq port; CTRL[9:8] are stored but have no effect.

Test Plan:
- Mode 0, WSZ=7, DATA write 0xA5; master sends 0x3C -> MISO shifts out 0xA5, DATA read returns 0x0000003C, RXFE=1 afterwards, TXHF=0.
- Modes 1, 2 and 3, WSZ=31, holding register 0xDEADBEEF; master sends 0x12345678 -> each mode returns 0x12345678 and MISO carries 0xDEADBEEF.
- Five 8-bit words 0x01-0x05 with no reads (RX_DEPTH=4) -> RXFF=1, RXFO=1, reads return 0x01-0x04; writing STATUS=0x4 clears RXFO.
- Frame with TXHF=0 -> MISO all zeros, TXU=1; cs_n raised after 3 of 8 bits -> no push, RXFE stays 1, BUSY=0.
- Read held for 4 cycles on a 2-entry FIFO -> exactly one pop. reset pulsed low mid-frame -> all outputs, CTRL and STATUS return to their reset values (RXFE=1).
- With SPI_SLAVE_IRQ_EN: IRQ_RX_EN=1, one word received -> irq=1; popping the word -> irq=0 next cycle.
